// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Frame controller placed behind a UART receiver. It accepts a stream of bytes,
// each marked by a one-cycle rx_flag pulse, and assembles them into a fixed
// four-byte command frame:
//
//     HEADER, ADDR, DATA, CHK      with CHK == (ADDR + DATA) mod 256
//
// For a frame with a good checksum it issues one single-cycle register write.
// A bad checksum produces a one-cycle frame_err pulse. If the line goes quiet
// for TO_CNT cycles in the middle of a frame, the frame is dropped and a
// one-cycle timeout_err pulse is produced.
//
// Ports:
//   sys_clk      in   1   system clock, rising edge
//   sys_rst      in   1   asynchronous reset, active high
//   rx_data      in   8   received byte, qualified by rx_flag
//   rx_flag      in   1   one-cycle byte-valid pulse
//   wr_en        out  1   one-cycle register-write strobe
//   wr_addr      out  8   write address, held until the next write
//   wr_data      out  8   write data, held until the next write
//   frame_err    out  1   one-cycle pulse on checksum mismatch
//   timeout_err  out  1   one-cycle pulse on inter-byte timeout
//   busy         out  1   high while a frame is in progress
//   good_cnt     out 16   number of accepted frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned UART_BPS      = 921_600,
    parameter logic [7:0]  HEADER        = 8'h55,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        busy,
    output logic [15:0] good_cnt
);

    // One UART byte is 10 bit times (start + 8 data + stop).
    localparam int unsigned TO_CNT  = TIMEOUT_BYTES * 10 * (CLK_FREQ / UART_BPS);
    localparam int unsigned TO_W    = $clog2(TO_CNT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t          state_q,       state_d;
    logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
    logic [7:0]      addr_q,        addr_d;
    logic [7:0]      data_q,        data_d;
    logic            wr_en_q,       wr_en_d;
    logic [7:0]      wr_addr_q,     wr_addr_d;
    logic [7:0]      wr_data_q,     wr_data_d;
    logic            frame_err_q,   frame_err_d;
    logic            timeout_err_q, timeout_err_d;
    logic            busy_q,        busy_d;
    logic [15:0]     good_cnt_q,    good_cnt_d;

    // 8-bit checksum; the carry out of the addition is deliberately dropped.
    logic [7:0] chk_sum;
    assign chk_sum = addr_q + data_q;

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // through this block can leave a value unassigned and infer a latch.
        state_d       = state_q;
        to_cnt_d      = to_cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        good_cnt_d    = good_cnt_q;

        // The inter-byte timer only advances while a frame is open.
        if (state_q != IDLE) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (rx_flag) begin
            // A byte always restarts the timer, even on the terminal count,
            // so a byte arriving exactly at the limit is accepted.
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    // Anything other than the header is line noise; drop it.
                    if (rx_data == HEADER) begin
                        state_d = S_ADDR;
                    end
                end
                // A header value inside a frame is just payload.
                S_ADDR: begin
                    addr_d  = rx_data;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    data_d  = rx_data;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    state_d = IDLE;
                    if (rx_data == chk_sum) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = data_q;
                        good_cnt_d = good_cnt_q + 16'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if ((state_q != IDLE) && (to_cnt_q == TO_LAST)) begin
            state_d       = IDLE;
            to_cnt_d      = '0;
            timeout_err_d = 1'b1;
        end

        // busy is registered from the next state so it lines up with state_q.
        busy_d = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            addr_q        <= 8'h00;
            data_q        <= 8'h00;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 8'h00;
            wr_data_q     <= 8'h00;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            good_cnt_q    <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the values computed from the same clock edge.
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign good_cnt    = good_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_parser
//
// Directed testbench for uart_cmd_parser at default parameters (timeout limit
// 2160 cycles). Inputs are driven on the falling clock edge and outputs are
// sampled on the falling edge, half a cycle after the edge that updates them.
// -----------------------------------------------------------------------------
module tb_uart_cmd_parser;

    localparam int unsigned TO_CNT = 2160;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_flag = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        frame_err;
    logic        timeout_err;
    logic        busy;
    logic [15:0] good_cnt;

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned n_wr      = 0;
    int unsigned n_ferr    = 0;
    int unsigned n_terr    = 0;
    int unsigned n_overlap = 0;

    uart_cmd_parser dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .good_cnt    (good_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters sampled on the rising edge (they see the value held
    // during the cycle that just ended).
    always @(posedge sys_clk) begin
        if (wr_en)       n_wr++;
        if (frame_err)   n_ferr++;
        if (timeout_err) n_terr++;
        if ((wr_en && frame_err) || (wr_en && timeout_err) || (frame_err && timeout_err))
            n_overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge, i.e. half a
    // cycle after the rising edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge sys_clk);
        rx_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] c, input int gap);
        send_byte(8'h55); idle(gap);
        send_byte(a);     idle(gap);
        send_byte(d);     idle(gap);
        send_byte(c);
    endtask

    initial begin
        // ---------------- reset ----------------
        idle(3);
        sys_rst = 1'b0;
        idle(1);
        check("rst_wr_en",   32'(wr_en),       32'h0);
        check("rst_busy",    32'(busy),        32'h0);
        check("rst_wr_addr", 32'(wr_addr),     32'h0);
        check("rst_wr_data", 32'(wr_data),     32'h0);
        check("rst_ferr",    32'(frame_err),   32'h0);
        check("rst_terr",    32'(timeout_err), 32'h0);
        check("rst_cnt",     32'(good_cnt),    32'h0);

        // ---------------- valid frame, 540 cycles between flags ----------------
        send_byte(8'h55); idle(539);
        check("v_busy_mid", 32'(busy), 32'h1);
        send_byte(8'h10); idle(539);
        send_byte(8'hA5); idle(539);
        send_byte(8'hB5);
        check("v_wr_en",   32'(wr_en),    32'h1);
        check("v_wr_addr", 32'(wr_addr),  32'h10);
        check("v_wr_data", 32'(wr_data),  32'hA5);
        check("v_cnt",     32'(good_cnt), 32'h1);
        check("v_busy",    32'(busy),     32'h0);
        idle(1);
        check("v_wr_en_1cyc", 32'(wr_en), 32'h0);

        // ---------------- bad checksum ----------------
        idle(2);
        send_frame(8'h22, 8'h33, 8'h56, 3);
        check("b_ferr",    32'(frame_err), 32'h1);
        check("b_wr_en",   32'(wr_en),     32'h0);
        check("b_wr_addr", 32'(wr_addr),   32'h10);
        check("b_wr_data", 32'(wr_data),   32'hA5);
        check("b_cnt",     32'(good_cnt),  32'h1);
        idle(1);
        check("b_ferr_1cyc", 32'(frame_err), 32'h0);
        idle(2);
        check("b_n_wr", n_wr, 32'd1);

        // ---------------- garbage then frame, then back-to-back frame ----------------
        send_byte(8'h00);
        check("g_busy_00", 32'(busy), 32'h0);
        idle(2);
        send_byte(8'hFF);
        check("g_busy_ff", 32'(busy), 32'h0);
        idle(2);
        send_frame(8'h01, 8'h02, 8'h03, 2);
        check("g_wr_en",   32'(wr_en),   32'h1);
        check("g_wr_addr", 32'(wr_addr), 32'h01);
        check("g_wr_data", 32'(wr_data), 32'h02);
        // Header arrives in the very cycle wr_en is high.
        send_frame(8'h07, 8'h08, 8'h0F, 0);
        check("g2_wr_en",   32'(wr_en),    32'h1);
        check("g2_wr_addr", 32'(wr_addr),  32'h07);
        check("g2_wr_data", 32'(wr_data),  32'h08);
        check("g2_cnt",     32'(good_cnt), 32'h3);
        // Checksum with carry discarded: F0 + 20 = 110 -> 10.
        idle(2);
        send_frame(8'hF0, 8'h20, 8'h10, 1);
        check("c_wr_en", 32'(wr_en),    32'h1);
        check("c_cnt",   32'(good_cnt), 32'h4);

        // ---------------- timeout ----------------
        idle(2);
        send_byte(8'h55); idle(2);
        send_byte(8'h20);
        idle(TO_CNT - 1);
        check("t_terr_early", 32'(timeout_err), 32'h0);
        check("t_busy_early", 32'(busy),        32'h1);
        idle(1);
        check("t_terr",  32'(timeout_err), 32'h1);
        check("t_busy",  32'(busy),        32'h0);
        check("t_wr_en", 32'(wr_en),       32'h0);
        idle(1);
        check("t_terr_1cyc", 32'(timeout_err), 32'h0);
        send_frame(8'h20, 8'h30, 8'h50, 2);
        check("t2_wr_en",   32'(wr_en),    32'h1);
        check("t2_wr_addr", 32'(wr_addr),  32'h20);
        check("t2_wr_data", 32'(wr_data),  32'h30);
        check("t2_cnt",     32'(good_cnt), 32'h5);

        // ---------------- terminal-count race ----------------
        idle(2);
        send_byte(8'h55);
        idle(TO_CNT - 1);
        send_byte(8'h33);              // consumed while the timer reads TO_CNT-1
        check("r_terr", 32'(timeout_err), 32'h0);
        check("r_busy", 32'(busy),        32'h1);
        idle(3);
        send_byte(8'h44); idle(3);
        send_byte(8'h77);
        check("r_wr_en",   32'(wr_en),    32'h1);
        check("r_wr_addr", 32'(wr_addr),  32'h33);
        check("r_wr_data", 32'(wr_data),  32'h44);
        check("r_cnt",     32'(good_cnt), 32'h6);
        idle(2);
        check("r_n_terr", n_terr, 32'd1);

        // ---------------- reset mid-frame ----------------
        send_byte(8'h55); idle(2);
        send_byte(8'h10); idle(2);
        #2 sys_rst = 1'b1;
        #1;
        check("m_busy",    32'(busy),     32'h0);
        check("m_wr_addr", 32'(wr_addr),  32'h0);
        check("m_wr_data", 32'(wr_data),  32'h0);
        check("m_cnt",     32'(good_cnt), 32'h0);
        idle(3);
        sys_rst = 1'b0;
        idle(2);
        check("m_n_wr", n_wr, 32'd6);
        send_frame(8'h01, 8'h01, 8'h02, 2);
        check("m2_wr_en",   32'(wr_en),    32'h1);
        check("m2_wr_addr", 32'(wr_addr),  32'h01);
        check("m2_wr_data", 32'(wr_data),  32'h01);
        check("m2_cnt",     32'(good_cnt), 32'h1);

        // ---------------- good_cnt wrap ----------------
        idle(2);
        force dut.good_cnt_q = 16'hFFFF;
        idle(1);
        release dut.good_cnt_q;
        idle(1);
        check("w_pre", 32'(good_cnt), 32'hFFFF);
        send_frame(8'h02, 8'h03, 8'h05, 1);
        check("w_wr_en", 32'(wr_en),    32'h1);
        check("w_cnt",   32'(good_cnt), 32'h0);

        // ---------------- pulse totals ----------------
        idle(3);
        check("tot_wr",      n_wr,      32'd8);
        check("tot_ferr",    n_ferr,    32'd1);
        check("tot_terr",    n_terr,    32'd1);
        check("tot_overlap", n_overlap, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
